// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
//   Round-robin burst arbiter and 32-bit data mux sharing one stream output
//   between N_REQ producers. A grant lasts up to BURST_MAX beats. Each grant
//   is followed by one IDLE arbitration cycle.
//
// Ports
//   clk           in   single clock, rising edge
//   rst_n         in   synchronous active-low reset
//   d_valid       in   [N_REQ]     per-requester valid
//   data_in       in   [N_REQ*DW]  flattened data, requester k at [k*DW +: DW]
//   p_ready       in   downstream ready
//   i_ready       out  [N_REQ]     per-requester ready, one-hot or zero
//   d_valid_out   out  output valid
//   data_out      out  [DW]        muxed output data
//   grant_idx     out  [4]         current / last owner (round-robin pointer)
//   grant_active  out  arbiter is in GRANT
//   grant_count   out  [32]        (ARB_STATS_EN only) IDLE->GRANT count, saturating
//   stall_count   out  [32]        (ARB_STATS_EN only) stalled GRANT cycles, saturating
//
// Optional feature macro: ARB_STATS_EN
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate: pick first valid requester above owner, wrapping
// GRANT | transfer beats from owner until burst limit or valid drops
module axis_rr_arbiter #(
    parameter int N_REQ     = 15,
    parameter int BURST_MAX = 4,
    parameter int DW        = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    d_valid,
    input  logic [N_REQ*DW-1:0] data_in,
    input  logic                p_ready,
    output logic [N_REQ-1:0]    i_ready,
    output logic                d_valid_out,
    output logic [DW-1:0]       data_out,
    output logic [3:0]          grant_idx,
`ifdef ARB_STATS_EN
    output logic [31:0]         grant_count,
    output logic [31:0]         stall_count,
`endif
    output logic                grant_active
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  owner;
    logic [7:0]  beat_cnt;

    logic [15:0] dv16;
    logic        dv_own;
    logic        grant;
    logic        transfer;
    logic        found;
    logic [3:0]  next_owner;
    logic [4:0]  sum;

    // Padded to 16 so a 4-bit owner index always addresses a real bit.
    assign dv16     = 16'(d_valid);
    assign dv_own   = dv16[owner];
    // Outputs read as idle while reset is asserted, even if state is still GRANT.
    assign grant    = (state == GRANT) && rst_n;
    assign transfer = grant && dv_own && p_ready;

    assign grant_active = grant;
    assign grant_idx    = owner;
    assign d_valid_out  = grant && dv_own;

    // Search owner+1 .. owner+N_REQ (mod N_REQ). Iterating downward lets the
    // nearest candidate overwrite farther ones, so the closest one wins.
    always_comb begin
        next_owner = owner;
        found      = 1'b0;
        sum        = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            sum = {1'b0, owner} + 5'(i);
            if (sum >= 5'(N_REQ)) begin
                sum = sum - 5'(N_REQ);
            end
            if (dv16[sum[3:0]]) begin
                next_owner = sum[3:0];
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        data_out = '0;
        i_ready  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant && (owner == 4'(k))) begin
                data_out   = data_in[k*DW +: DW];
                i_ready[k] = p_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 4'(N_REQ-1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner    <= next_owner;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (!dv_own) begin
                        state <= IDLE;
                    end else if (p_ready) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (beat_cnt == 8'(BURST_MAX-1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_count <= '0;
            stall_count <= '0;
        end else begin
            if ((state == IDLE) && found && (grant_count != 32'hFFFF_FFFF)) begin
                grant_count <= grant_count + 32'd1;
            end
            if ((state == GRANT) && dv_own && !p_ready && (stall_count != 32'hFFFF_FFFF)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

    // beat_cnt only matters while granted; transfer is kept for readability of
    // the handshake and feeds nothing else.
    logic unused_ok;
    assign unused_ok = transfer;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

    localparam int N_REQ = 15;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    d_valid;
    logic [N_REQ*DW-1:0] data_in;
    logic                p_ready;
    logic [N_REQ-1:0]    i_ready;
    logic                d_valid_out;
    logic [DW-1:0]       data_out;
    logic [3:0]          grant_idx;
    logic                grant_active;
`ifdef ARB_STATS_EN
    logic [31:0]         grant_count;
    logic [31:0]         stall_count;
    logic [31:0]         stall_base;
`endif

    axis_rr_arbiter #(.N_REQ(N_REQ), .BURST_MAX(4), .DW(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .d_valid      (d_valid),
        .data_in      (data_in),
        .p_ready      (p_ready),
        .i_ready      (i_ready),
        .d_valid_out  (d_valid_out),
        .data_out     (data_out),
        .grant_idx    (grant_idx),
`ifdef ARB_STATS_EN
        .grant_count  (grant_count),
        .stall_count  (stall_count),
`endif
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int idx, input int n);
        exp_t e;
        e.idx  = 4'(idx);
        e.data = 32'(idx + 1);
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each accepted beat must match the next queued expectation;
    // outside a grant the output side must be fully quiet.
    always @(negedge clk) begin
        exp_t e;
        if (d_valid_out && p_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {60'd0, grant_idx}, 64'hFF);
            end else begin
                e = exp_q.pop_front();
                check("beat_idx",   {60'd0, grant_idx}, {60'd0, e.idx});
                check("beat_data",  {32'd0, data_out},  {32'd0, e.data});
                check("beat_ready", {49'd0, i_ready},   {49'd0, 15'(1) << e.idx});
            end
        end else if (!grant_active) begin
            check("idle_quiet", {32'd0, d_valid_out, 16'd0, i_ready}, 64'd0);
            check("idle_data",  {32'd0, data_out}, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < N_REQ; k++) data_in[k*DW +: DW] = 32'(k + 1);
        rst_n   = 1'b0;
        d_valid = '0;
        p_ready = 1'b0;

        // Reset and idle
        repeat (3) step();
        check("rst_active", {63'd0, grant_active}, 64'd0);
        check("rst_idx",    {60'd0, grant_idx},    64'd14);
        rst_n = 1'b1;
        step();
        step();
        check("idle_idx", {60'd0, grant_idx}, 64'd14);
`ifdef ARB_STATS_EN
        check("rst_gcnt", {32'd0, grant_count}, 64'd0);
`endif

        // Single requester: 4 beats, one bubble, regrant
        d_valid = 15'h0004;
        p_ready = 1'b1;
        push(2, 8);
        step();
        check("single_g1_active", {63'd0, grant_active}, 64'd1);
        check("single_g1_idx",    {60'd0, grant_idx},    64'd2);
        repeat (3) step();
        step();
        check("single_bubble", {63'd0, grant_active}, 64'd0);
        check("single_bubble_idx", {60'd0, grant_idx}, 64'd2);
        step();
        check("single_g2_idx", {59'd0, grant_active, grant_idx}, {59'd0, 1'b1, 4'd2});
        repeat (3) step();
        step();
        d_valid = '0;
        check("single_end", {63'd0, grant_active}, 64'd0);

        // Round robin between 0 and 2
        step();
        d_valid = 15'h0005;
        push(0, 4); push(2, 4); push(0, 4); push(2, 4);
        for (int g = 0; g < 4; g++) begin
            step();
            check("rr_grant", {59'd0, grant_active, grant_idx},
                  {59'd0, 1'b1, ((g % 2) == 1) ? 4'd2 : 4'd0});
            repeat (3) step();
            step();
            check("rr_bubble", {63'd0, grant_active}, 64'd0);
            if (g == 3) d_valid = '0;
        end

        // Stall mid-burst on owner 1 while 2 is also requesting
        step();
        d_valid = 15'h0006;
        push(1, 4);
        step();
        check("stall_grant", {59'd0, grant_active, grant_idx}, {59'd0, 1'b1, 4'd1});
`ifdef ARB_STATS_EN
        stall_base = stall_count;
`endif
        step();
        for (int i = 0; i < 6; i++) begin
            step();
            p_ready = 1'b0;
            #1;
            check("stall_hold", {59'd0, grant_active, grant_idx}, {59'd0, 1'b1, 4'd1});
            check("stall_ready", {49'd0, i_ready}, 64'd0);
        end
        step();
        p_ready = 1'b1;
        step();
        step();
        check("stall_release", {63'd0, grant_active}, 64'd0);
`ifdef ARB_STATS_EN
        check("stall_count", {32'd0, stall_count - stall_base}, 64'd6);
`endif
        d_valid = '0;

        // Early release by owner 14, wrap to requester 0
        step();
        d_valid = 15'h4001;
        push(14, 2);
        push(0, 4);
        step();
        check("wrap_g14", {59'd0, grant_active, grant_idx}, {59'd0, 1'b1, 4'd14});
        step();
        step();
        d_valid = 15'h0001;
        step();
        check("early_idle", {63'd0, grant_active}, 64'd0);
        step();
        check("wrap_g0", {59'd0, grant_active, grant_idx}, {59'd0, 1'b1, 4'd0});
        repeat (3) step();
        step();
        d_valid = '0;

        // Reset during owner 5's burst
        step();
        d_valid = 15'h0021;
        push(5, 2);
        push(0, 4);
        step();
        check("rst_mid_g5", {59'd0, grant_active, grant_idx}, {59'd0, 1'b1, 4'd5});
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_quiet", {62'd0, grant_active, d_valid_out}, 64'd0);
        step();
        rst_n = 1'b1;
        check("rst_mid_after", {59'd0, grant_active, grant_idx}, {59'd0, 1'b0, 4'd14});
        step();
        check("rst_mid_regrant", {59'd0, grant_active, grant_idx}, {59'd0, 1'b1, 4'd0});
        repeat (3) step();
        step();
        d_valid = '0;
        repeat (3) step();

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Round-robin burst arbiter and data mux that shares one 32-bit AXI-stream-style output between up to 16 producers. It sits in front of the downstream consumer in the same position as the stream interconnect. It owns the `d_valid`/`i_ready`/`p_ready` handshake per requester, holds a grant for a bounded burst, and sequences fair access with a one-cycle arbitration slot between grants.

## Interface
- `N_REQ`, 15: number of requesters; legal range 2..16.
- `BURST_MAX`, 4: maximum beats per grant; legal range 1..255.
- `DW`, 32: data width per requester.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `d_valid` in N_REQ: per-requester data valid.
- `data_in` in N_REQ*DW: flattened input data; requester k occupies bits [k*DW +: DW].
- `p_ready` in 1: downstream ready.
- `i_ready` out N_REQ: per-requester ready. One-hot or zero.
- `d_valid_out` out 1: output data valid.
- `data_out` out DW: muxed output data.
- `grant_idx` out 4: current owner index. Valid when `grant_active`=1.
- `grant_active` out 1: arbiter is in GRANT state.

## Operation
- States: IDLE (arbitrate) and GRANT (transfer).
- Registers:
  - `owner` (4b), reset N_REQ-1.
  - `beat_cnt` (8b), reset 0.
  - `state`, reset IDLE.
- IDLE behaviour:
  - If any `d_valid` is set, select the first set bit searching upward from `owner+1` mod N_REQ, wrapping.
  - Load that index into `owner`, clear `beat_cnt`, and go to GRANT.
  - If `d_valid` is all zero, stay in IDLE.
- GRANT behaviour:
  - `d_valid_out = d_valid[owner]`.
  - `data_out = data_in[owner]`.
  - `i_ready = p_ready << owner`.
  - A transfer occurs when `d_valid[owner] & p_ready`.
  - On a transfer, `beat_cnt` increments.
- Release to IDLE on either condition:
  - A transfer occurs with `beat_cnt == BURST_MAX-1`.
  - `d_valid[owner]==0` (no transfer that cycle).
- `owner` keeps its value after release, so it serves as the round-robin pointer. The just-served requester gets lowest priority next arbitration.
- In IDLE, and during reset:
  - `i_ready = 0`.
  - `d_valid_out = 0`.
  - `data_out = 0`.
  - `grant_active = 0`.
- `grant_idx` mirrors `owner` at all times.
- Requests from non-owners during GRANT are ignored until the next IDLE cycle.
- `p_ready` low holds the grant indefinitely; `beat_cnt` does not advance.
- Reset mid-burst:
  - Next cycle is IDLE with `owner = N_REQ-1`.
  - No transfer is reported in the reset cycle.

## Timing
- Arbitration latency: `d_valid` sampled high in IDLE at edge n gives GRANT and an output beat from cycle n+1. All outputs are combinational from registered state and current inputs.
- Throughput:
  - Uninterrupted burst: BURST_MAX beats per BURST_MAX+1 cycles.
  - Single active requester: re-granted after each one-cycle IDLE bubble.
- Release decision is registered. The state is IDLE in the cycle after the last beat.
- No combinational path from `p_ready` to `d_valid_out`. Paths exist `p_ready`→`i_ready` and `d_valid`→`d_valid_out`.

## Configuration
- `ARB_STATS_EN` defined adds two outputs:
  - `grant_count` (32b): increments on each IDLE→GRANT.
  - `stall_count` (32b): increments each GRANT cycle with `d_valid[owner] & ~p_ready`.
  - Both saturate at 32'hFFFFFFFF.
  - Both clear on `rst_n=0`.
- `ARB_STATS_EN` undefined: the two ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset and idle:
  - Stimulus: `rst_n=0` for 3 cycles, then `d_valid=0`.
  - Required: all outputs 0 and `grant_idx=14` (N_REQ=15).
- Single requester:
  - Stimulus: `data_in` k = k+1, `d_valid=15'h0004`, `p_ready=1`.
  - Required: grant to 2; `data_out=32'h3` for 4 beats; 1 IDLE cycle; regrant to 2.
- Round robin:
  - Stimulus: `d_valid=15'h0005`, `p_ready=1`.
  - Required: grants alternate 0, 2, 0, 2; each burst is 4 beats; `i_ready` = `15'h0001` / `15'h0004`.
- Stall:
  - Stimulus: `p_ready=0` for 6 cycles mid-burst on owner 1 (`d_valid=15'h0006`).
  - Required: `grant_idx=1` held; `i_ready=0`; `beat_cnt` frozen; remaining beats complete after `p_ready=1`; `stall_count` +6 with `ARB_STATS_EN`.
- Early release and wrap:
  - Stimulus: owner 14 drops `d_valid` after 2 beats while requester 0 is pending.
  - Required: IDLE next cycle, then grant to 0 (wrap-around).
- Reset mid-burst:
  - Stimulus: `rst_n=0` for one cycle during owner 5's burst.
  - Required: `grant_active=0` next cycle; next grant goes to the lowest pending index from 0.
